// File: rtl/sonar_frame_parser.sv
// -----------------------------------------------------------------------------
// sonar_frame_parser
//   Receive-side parser for the sonar serial link. Bytes arrive from a UART
//   receiver and are matched against the frame layout "aaa,mmm#" (three angle
//   digits, comma, three distance digits, hash; hundreds digit first). A
//   well-formed frame publishes the angle and distance as BCD and binary and
//   pulses frame_valido. A malformed or stalled frame pulses erro (once) and the
//   parser resynchronises on the next '#'.
//
// Parameters:
//   TIMEOUT_CICLOS   inter-byte timeout in clock cycles (>= 2)
//   LARGURA_TIMEOUT  timeout counter width, 2**LARGURA_TIMEOUT > TIMEOUT_CICLOS
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous, active-high
//   dado_recebido    received byte, valid while pronto_recepcao = 1
//   pronto_recepcao  one-cycle strobe per received byte
//   angulo_bcd       last accepted angle, BCD {c,d,u}
//   distancia_bcd    last accepted distance, BCD {c,d,u}
//   angulo_bin       last accepted angle, binary
//   distancia_bin    last accepted distance, binary
//   frame_valido     one-cycle pulse when a frame is accepted
//   erro             one-cycle pulse when a frame is rejected
//   num_frames       accepted frame count, wraps 255 -> 0
//   db_estado        current parser state code (debug)
// -----------------------------------------------------------------------------
module sonar_frame_parser #(
  parameter int TIMEOUT_CICLOS  = 5000000,
  parameter int LARGURA_TIMEOUT = 23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  dado_recebido,
  input  logic        pronto_recepcao,
  output logic [11:0] angulo_bcd,
  output logic [11:0] distancia_bcd,
  output logic [9:0]  angulo_bin,
  output logic [9:0]  distancia_bin,
  output logic        frame_valido,
  output logic        erro,
  output logic [7:0]  num_frames,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    ANG_C    = 4'd0,
    ANG_D    = 4'd1,
    ANG_U    = 4'd2,
    VIRG     = 4'd3,
    MED_C    = 4'd4,
    MED_D    = 4'd5,
    MED_U    = 4'd6,
    HASH     = 4'd7,
    DESCARTA = 4'd8
  } estado_t;

  // The counter value at which the next idle cycle completes the timeout.
  localparam logic [LARGURA_TIMEOUT-1:0] LIMITE = LARGURA_TIMEOUT'(TIMEOUT_CICLOS - 1);
  localparam logic [LARGURA_TIMEOUT-1:0] UM     = LARGURA_TIMEOUT'(1);

  estado_t                    estado;
  logic [LARGURA_TIMEOUT-1:0] contador;
  logic [11:0]                ang_sombra;
  logic [11:0]                dist_sombra;
  // Accept/reject events are staged one cycle so both strobes leave from the
  // same pipeline stage and can never coincide.
  logic                       commit_pendente;
  logic                       erro_pendente;

  logic                       eh_digito;
  logic                       eh_virgula;
  logic                       eh_hash;
  logic                       byte_esperado;

  function automatic logic [9:0] bcd_para_bin(input logic [11:0] bcd);
    return ({6'd0, bcd[11:8]} * 10'd100) + ({6'd0, bcd[7:4]} * 10'd10) + {6'd0, bcd[3:0]};
  endfunction

  assign db_estado = estado;

  // Classify the incoming byte against what the current state expects.
  always_comb begin
    eh_digito     = (dado_recebido[7:4] == 4'h3) && (dado_recebido[3:0] <= 4'h9);
    eh_virgula    = (dado_recebido == 8'h2C);
    eh_hash       = (dado_recebido == 8'h23);
    byte_esperado = 1'b0;
    case (estado)
      ANG_C, ANG_D, ANG_U, MED_C, MED_D, MED_U: byte_esperado = eh_digito;
      VIRG:                                     byte_esperado = eh_virgula;
      HASH:                                     byte_esperado = eh_hash;
      default:                                  byte_esperado = 1'b0;
    endcase
  end

  // Parser FSM, timeout counter, shadow registers and published outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado          <= ANG_C;
      contador        <= '0;
      ang_sombra      <= 12'd0;
      dist_sombra     <= 12'd0;
      commit_pendente <= 1'b0;
      erro_pendente   <= 1'b0;
      angulo_bcd      <= 12'd0;
      distancia_bcd   <= 12'd0;
      angulo_bin      <= 10'd0;
      distancia_bin   <= 10'd0;
      frame_valido    <= 1'b0;
      erro            <= 1'b0;
      num_frames      <= 8'd0;
    end else begin
      frame_valido    <= commit_pendente;
      erro            <= erro_pendente;
      commit_pendente <= 1'b0;
      erro_pendente   <= 1'b0;

      // Shadows are sampled before any byte in this cycle overwrites them.
      if (commit_pendente) begin
        angulo_bcd    <= ang_sombra;
        distancia_bcd <= dist_sombra;
        angulo_bin    <= bcd_para_bin(ang_sombra);
        distancia_bin <= bcd_para_bin(dist_sombra);
        num_frames    <= num_frames + 8'd1;
      end

      if (pronto_recepcao) begin
        // A byte always takes precedence over a coincident timeout.
        contador <= '0;
        if (estado == DESCARTA) begin
          if (eh_hash) begin
            estado <= ANG_C;
          end else begin
            estado <= DESCARTA;
          end
        end else if (byte_esperado) begin
          case (estado)
            ANG_C: begin ang_sombra[11:8]  <= dado_recebido[3:0]; estado <= ANG_D; end
            ANG_D: begin ang_sombra[7:4]   <= dado_recebido[3:0]; estado <= ANG_U; end
            ANG_U: begin ang_sombra[3:0]   <= dado_recebido[3:0]; estado <= VIRG;  end
            VIRG:  begin estado <= MED_C; end
            MED_C: begin dist_sombra[11:8] <= dado_recebido[3:0]; estado <= MED_D; end
            MED_D: begin dist_sombra[7:4]  <= dado_recebido[3:0]; estado <= MED_U; end
            MED_U: begin dist_sombra[3:0]  <= dado_recebido[3:0]; estado <= HASH;  end
            HASH:  begin estado <= ANG_C; commit_pendente <= 1'b1; end
            default: estado <= ANG_C;
          endcase
        end else begin
          // A stray '#' already marks a frame boundary, so resync directly.
          erro_pendente <= 1'b1;
          if (eh_hash) begin
            estado <= ANG_C;
          end else begin
            estado <= DESCARTA;
          end
        end
      end else if (estado != ANG_C) begin
        if (contador == LIMITE) begin
          contador      <= '0;
          estado        <= ANG_C;
          erro_pendente <= (estado != DESCARTA);
        end else begin
          contador <= contador + UM;
        end
      end else begin
        contador <= '0;
      end
    end
  end

endmodule

// File: doc/sonar_frame_parser.md
Name: sonar_frame_parser

Overview:
- Receive side of the sonar serial link. Consumes bytes from a UART receiver and parses frames of the form "aaa,mmm#" (angle digits, comma, distance digits, hash).
- Each frame carries 3 ASCII angle digits and 3 ASCII distance digits, hundreds digit first.
- On a well-formed frame it latches both values as BCD and binary and pulses a valid strobe. Malformed or stalled frames are rejected and the parser resynchronises on the next '#'.
- Sits on the host/monitor board between the UART receiver and the display/logging logic.

Parameters:
TIMEOUT_CICLOS, 5000000, inter-byte timeout in clock cycles (100 ms at 50 MHz); minimum legal value 2
LARGURA_TIMEOUT, 23, counter width; must satisfy 2^LARGURA_TIMEOUT > TIMEOUT_CICLOS

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
dado_recebido  input  8  received byte; valid only while pronto_recepcao=1
pronto_recepcao  input  1  one-cycle strobe, one per received byte
angulo_bcd  output  12  last valid angle, BCD {c,d,u}
distancia_bcd  output  12  last valid distance, BCD {c,d,u}
angulo_bin  output  10  last valid angle, binary
distancia_bin  output  10  last valid distance, binary
frame_valido  output  1  one-cycle pulse on frame accept
erro  output  1  one-cycle pulse on frame reject
num_frames  output  8  count of accepted frames, wraps 255->0
db_estado  output  4  current state code

Behaviour:
- Reset (async): state ANG_C. All outputs 0. Timeout counter 0. Digit shadow registers 0.
- Byte events occur only on cycles with pronto_recepcao=1. Other cycles change no parse state, except the timeout counter.
- Digit = 0x30..0x39; the stored nibble is byte[3:0].
- States and db_estado codes, with the byte expected in each:
  - 0 ANG_C, 1 ANG_D, 2 ANG_U: digit
  - 3 VIRG: ','
  - 4 MED_C, 5 MED_D, 6 MED_U: digit
  - 7 HASH: '#'
  - 8 DESCARTA: none; discarding
- Expected byte in states 0–7: store the digit in the shadow register where applicable, then advance to the next state.
- Expected '#' in HASH:
  - next state ANG_C
  - on the following edge, commit shadows to angulo_bcd/distancia_bcd
  - commit angulo_bin = c*100+d*10+u, and distancia_bin likewise (max 999 fits in 10 bits)
  - frame_valido=1 for exactly that one cycle; num_frames increments
  - Latency: '#' strobe at edge N yields updated outputs and frame_valido visible after edge N+1.
- Unexpected byte in states 0–7:
  - if the byte is '#': erro pulse, next state ANG_C (immediate resync)
  - otherwise: erro pulse, next state DESCARTA
  - Published outputs are unchanged in both cases.
- DESCARTA: '#' leads to ANG_C. Any other byte is ignored. No further erro pulses are generated.
- Timeout:
  - Counter clears on every strobe and on entry to ANG_C.
  - It increments each cycle while state != ANG_C and no strobe is present.
  - When it reaches TIMEOUT_CICLOS: next state ANG_C, counter cleared.
  - erro pulses if the state was 1–7; no erro if the state was DESCARTA.
  - A strobe in the same cycle as timeout expiry: the strobe wins and is processed normally; the counter clears.
- frame_valido and erro are registered, never high simultaneously, and never high for two consecutive cycles from a single event.
- Published values hold until the next accepted frame. A partial frame never alters them.
- Reset asserted mid-frame aborts immediately. Shadow registers are lost and outputs return to 0.

Test Plan:
- Send "090,045#" with bytes 20 cycles apart -> after '#' +1 edge: angulo_bcd=0x090, angulo_bin=90, distancia_bcd=0x045, distancia_bin=45, frame_valido pulse width 1, num_frames=1.
- Send "180,999#" then "000,000#" -> first frame gives angulo_bin=180, distancia_bin=999; second gives both 0; num_frames=2; db_estado=0 after each.
- Send "1A0,020#" then "030,040#" -> erro pulses once at 'A'; '0','2','0','#' are discarded without further erro; next frame accepted with angulo_bin=30, distancia_bin=40; outputs held previous values in between.
- Send "12#" then "045,123#" -> erro on '#' with direct return to ANG_C; second frame accepted (45, 123).
- Send "045,1", then idle TIMEOUT_CICLOS cycles (bench TIMEOUT_CICLOS=100) -> erro at cycle 100, state ANG_C. Then "011,022#" is accepted. A strobe on exactly cycle 100 is processed instead of timing out.
- Assert reset after "123,4" -> all outputs 0, db_estado=0. Then "123,456#" yields angulo_bin=123, distancia_bin=456, num_frames=1. Also run 256 valid frames -> num_frames wraps to 0.
